cyclic_prefix_insertion: RTL

- Transmit-side counterpart of the cyclicPrefixRemoval kernel.
- Accepts OFDM symbols of FFT_LEN samples on AXI4-Stream `inpstream` and emits each one on AXI4-Stream `oupstream` as CP_LEN + FFT_LEN samples, prefixed with a copy of its last CP_LEN samples.
- Ping-pong buffered: one symbol fills while the previous one drains.
- Sits between the IFFT output and the DAC/framing path.

---
 rtl/cyclic_prefix_insertion.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cyclic_prefix_insertion.sv
// Cyclic prefix insertion: buffers FFT_LEN-sample OFDM symbols in two banks and
// replays each as its last CP_LEN samples followed by the whole symbol.
module cyclic_prefix_insertion #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FFT_LEN = 64,
    parameter int unsigned CP_LEN  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] inpstream_TDATA,
    input  logic              inpstream_TVALID,
    output logic              inpstream_TREADY,
    input  logic              inpstream_TLAST,
    output logic [DATA_W-1:0] oupstream_TDATA,
    output logic              oupstream_TVALID,
    input  logic              oupstream_TREADY,
    output logic              oupstream_TLAST,
    output logic [CNT_W-1:0]  sym_in_cnt,
    output logic [CNT_W-1:0]  sym_out_cnt,
    output logic              tlast_err
);

    localparam int unsigned ADDR_W = $clog2(FFT_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_LEN - 1);
    localparam logic [ADDR_W-1:0] CP_START  = ADDR_W'(FFT_LEN - CP_LEN);

    typedef enum logic [1:0] {IDLE, PREFIX, BODY} rd_state_t;

    logic [DATA_W-1:0] mem [2*FFT_LEN];

    rd_state_t         state, state_n;
    logic [1:0]        full, full_n;
    logic              wr_bank, wr_bank_n, rd_bank;
    logic [ADDR_W-1:0] wr_addr, rd_addr, rd_addr_n, issue_addr_c;
    logic              wr_fire_c, wr_done_c, pop_c, issue_ok_c, issue_c;
    logic              issue_last_c, release_c;

    logic              rd_valid, rd_last;
    logic [DATA_W-1:0] rd_data;
    logic              skid_valid, skid_last;
    logic [DATA_W-1:0] skid_data;

    // Write accounting, read issue and bank flag next-state
    always_comb begin
        wr_fire_c    = inpstream_TVALID && inpstream_TREADY;
        wr_done_c    = wr_fire_c && (wr_addr == LAST_ADDR);
        pop_c        = oupstream_TVALID && oupstream_TREADY;
        // a read may issue only if its data is sure to find a free slot
        issue_ok_c   = ({1'b0, oupstream_TVALID} + {1'b0, skid_valid} + {1'b0, rd_valid})
                       <= (2'd1 + {1'b0, pop_c});
        issue_addr_c = (state == IDLE) ? CP_START : rd_addr;
        issue_c      = issue_ok_c && full[rd_bank];
        state_n      = state;
        rd_addr_n    = rd_addr;
        issue_last_c = 1'b0;
        release_c    = 1'b0;
        if (issue_c) begin
            if (state == BODY) begin
                if (rd_addr == LAST_ADDR) begin
                    issue_last_c = 1'b1;
                    release_c    = 1'b1;
                    if (full[~rd_bank]) begin
                        state_n   = PREFIX;
                        rd_addr_n = CP_START;
                    end else begin
                        state_n   = IDLE;
                        rd_addr_n = '0;
                    end
                end else begin
                    rd_addr_n = rd_addr + 1'b1;
                end
            end else if (issue_addr_c == LAST_ADDR) begin
                state_n   = BODY;
                rd_addr_n = '0;
            end else begin
                state_n   = PREFIX;
                rd_addr_n = issue_addr_c + 1'b1;
            end
        end
        full_n = full;
        if (wr_done_c) full_n[wr_bank] = 1'b1;
        if (release_c) full_n[rd_bank] = 1'b0;
        wr_bank_n = wr_bank ^ wr_done_c;
    end

    // Sample storage with registered read port
    always_ff @(posedge ap_clk) begin
        if (wr_fire_c) mem[{wr_bank, wr_addr}] <= inpstream_TDATA;
        if (issue_c)   rd_data <= mem[{rd_bank, issue_addr_c}];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= IDLE;
            full             <= '0;
            wr_bank          <= 1'b0;
            rd_bank          <= 1'b0;
            wr_addr          <= '0;
            rd_addr          <= '0;
            inpstream_TREADY <= 1'b0;
            sym_in_cnt       <= '0;
            sym_out_cnt      <= '0;
            tlast_err        <= 1'b0;
            rd_valid         <= 1'b0;
            rd_last          <= 1'b0;
            skid_valid       <= 1'b0;
            skid_last        <= 1'b0;
            skid_data        <= '0;
            oupstream_TVALID <= 1'b0;
            oupstream_TLAST  <= 1'b0;
            oupstream_TDATA  <= '0;
        end else begin
            state            <= state_n;
            rd_addr          <= rd_addr_n;
            full             <= full_n;
            wr_bank          <= wr_bank_n;
            rd_bank          <= rd_bank ^ release_c;
            inpstream_TREADY <= !full_n[wr_bank_n];
            if (wr_fire_c) begin
                wr_addr <= wr_done_c ? '0 : wr_addr + 1'b1;
                if (inpstream_TLAST != (wr_addr == LAST_ADDR)) tlast_err <= 1'b1;
            end
            if (wr_done_c) sym_in_cnt <= sym_in_cnt + 1'b1;
            if (pop_c && oupstream_TLAST) sym_out_cnt <= sym_out_cnt + 1'b1;
            rd_valid <= issue_c;
            rd_last  <= issue_last_c;
            // Output register plus one skid entry
            if (!oupstream_TVALID || pop_c) begin
                if (skid_valid) begin
                    oupstream_TVALID <= 1'b1;
                    oupstream_TDATA  <= skid_data;
                    oupstream_TLAST  <= skid_last;
                    skid_valid       <= rd_valid;
                    if (rd_valid) begin
                        skid_data <= rd_data;
                        skid_last <= rd_last;
                    end
                end else begin
                    oupstream_TVALID <= rd_valid;
                    if (rd_valid) begin
                        oupstream_TDATA <= rd_data;
                        oupstream_TLAST <= rd_last;
                    end
                end
            end else if (rd_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= rd_last;
            end
        end
    end

endmodule
